// File: rtl/wb_regfile.sv
// Writeback stage: selects the writeback value, commits it to the GPR file,
// serves two write-first bypassed read ports and counts retired writebacks.
module wb_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_NUM    = 32,
    parameter int CNT_WIDTH  = 32,
    localparam int AW        = $clog2(REG_NUM)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            i_WB,
    input  logic [DATA_WIDTH-1:0] i_dataread,
    input  logic [DATA_WIDTH-1:0] i_alures,
    input  logic [AW-1:0]         i_wreg,
    input  logic [AW-1:0]         i_raddr1,
    input  logic [AW-1:0]         i_raddr2,
    output logic [DATA_WIDTH-1:0] o_rdata1,
    output logic [DATA_WIDTH-1:0] o_rdata2,
    output logic [DATA_WIDTH-1:0] o_wbdata,
    output logic                  o_wben,
    output logic [CNT_WIDTH-1:0]  o_wbcount
);

    logic [DATA_WIDTH-1:0] regs_q [REG_NUM];
    logic [DATA_WIDTH-1:0] regs_d [REG_NUM];
    logic [CNT_WIDTH-1:0]  wbcount_q;
    logic [CNT_WIDTH-1:0]  wbcount_d;
    logic [DATA_WIDTH-1:0] wbdata;
    logic                  wben;
    logic [DATA_WIDTH-1:0] rdata1;
    logic [DATA_WIDTH-1:0] rdata2;

    // Writeback mux and effective write enable (never for r0, never in reset)
    always_comb begin
        wbdata = i_WB[0] ? i_dataread : i_alures;
        wben   = !rst && i_WB[1] && (i_wreg != '0);
    end

    // Next-state of the register file and the retired-writeback counter
    always_comb begin
        regs_d    = regs_q;
        wbcount_d = wbcount_q;
        if (wben) begin
            regs_d[i_wreg] = wbdata;
            wbcount_d      = wbcount_q + CNT_WIDTH'(1);
        end
        regs_d[0] = '0;
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q    <= '{default: '0};
            wbcount_q <= '0;
        end else begin
            regs_q    <= regs_d;
            wbcount_q <= wbcount_d;
        end
    end

    // Read port 1: write-first bypass from the current writeback
    always_comb begin
        rdata1 = '0;
        if (!rst) begin
            if (i_raddr1 != '0 && wben && i_raddr1 == i_wreg) rdata1 = wbdata;
            else                                              rdata1 = regs_q[i_raddr1];
        end
    end

    // Read port 2: write-first bypass from the current writeback
    always_comb begin
        rdata2 = '0;
        if (!rst) begin
            if (i_raddr2 != '0 && wben && i_raddr2 == i_wreg) rdata2 = wbdata;
            else                                              rdata2 = regs_q[i_raddr2];
        end
    end

    assign o_rdata1  = rdata1;
    assign o_rdata2  = rdata2;
    assign o_wbdata  = wbdata;
    assign o_wben    = wben;
    assign o_wbcount = wbcount_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: the driver computes the expected outputs
// from an array model of the register file and queues them; the monitor
// samples the DUT on the falling edge and compares.
module tb_wb_regfile;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    i_WB;
    logic [DW-1:0] i_dataread;
    logic [DW-1:0] i_alures;
    logic [4:0]    i_wreg;
    logic [4:0]    i_raddr1;
    logic [4:0]    i_raddr2;
    logic [DW-1:0] o_rdata1;
    logic [DW-1:0] o_rdata2;
    logic [DW-1:0] o_wbdata;
    logic          o_wben;
    logic [CW-1:0] o_wbcount;

    always #5 clk = ~clk;

    wb_regfile #(
        .DATA_WIDTH(DW),
        .REG_NUM   (32),
        .CNT_WIDTH (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_WB      (i_WB),
        .i_dataread(i_dataread),
        .i_alures  (i_alures),
        .i_wreg    (i_wreg),
        .i_raddr1  (i_raddr1),
        .i_raddr2  (i_raddr2),
        .o_rdata1  (o_rdata1),
        .o_rdata2  (o_rdata2),
        .o_wbdata  (o_wbdata),
        .o_wben    (o_wben),
        .o_wbcount (o_wbcount)
    );

    typedef struct {
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [DW-1:0] wbd;
        logic          wen;
        logic [CW-1:0] cnt;
        int            id;
    } exp_t;

    exp_t          sbq[$];
    exp_t          mon_e;
    logic [DW-1:0] mreg [32];
    int unsigned   mcnt = 0;
    int            step_id = 0;
    int            n_checks = 0;
    int            n_fail = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp, input int id);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got %h expected %h", nm, id, act, exp);
        end
    endtask

    // One cycle of stimulus; expected outputs follow directly from the
    // architectural rules applied to the model state before the edge.
    task automatic step(input logic r, input logic [1:0] w, input logic [DW-1:0] dr,
                        input logic [DW-1:0] alu, input logic [4:0] wr,
                        input logic [4:0] a1, input logic [4:0] a2);
        exp_t          e;
        logic          en;
        logic [DW-1:0] wd;
        @(posedge clk);
        #1;
        rst        = r;
        i_WB       = w;
        i_dataread = dr;
        i_alures   = alu;
        i_wreg     = wr;
        i_raddr1   = a1;
        i_raddr2   = a2;
        if (r) begin
            foreach (mreg[i]) mreg[i] = '0;
            mcnt = 0;
        end
        wd    = w[0] ? dr : alu;
        en    = !r && w[1] && (wr != 5'd0);
        e.wbd = wd;
        e.wen = en;
        e.cnt = CW'(mcnt);
        e.id  = step_id;
        if (r)                                e.rd1 = '0;
        else if (a1 != 0 && en && a1 == wr)   e.rd1 = wd;
        else                                  e.rd1 = mreg[a1];
        if (r)                                e.rd2 = '0;
        else if (a2 != 0 && en && a2 == wr)   e.rd2 = wd;
        else                                  e.rd2 = mreg[a2];
        sbq.push_back(e);
        step_id++;
        if (en) begin
            mreg[wr] = wd;
            mcnt     = (mcnt + 1) % (1 << CW);
        end
    endtask

    // Monitor: every cycle with a queued expectation is compared mid-cycle
    always @(negedge clk) begin
        if (sbq.size() != 0) begin
            mon_e = sbq.pop_front();
            chk("rdata1",  o_rdata1,        mon_e.rd1,        mon_e.id);
            chk("rdata2",  o_rdata2,        mon_e.rd2,        mon_e.id);
            chk("wbdata",  o_wbdata,        mon_e.wbd,        mon_e.id);
            chk("wben",    DW'(o_wben),     DW'(mon_e.wen),   mon_e.id);
            chk("wbcount", DW'(o_wbcount),  DW'(mon_e.cnt),   mon_e.id);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] wr;
        logic [4:0] a1;
        logic [4:0] a2;
        rst        = 1'b1;
        i_WB       = 2'b00;
        i_dataread = '0;
        i_alures   = '0;
        i_wreg     = '0;
        i_raddr1   = '0;
        i_raddr2   = '0;
        foreach (mreg[i]) mreg[i] = '0;

        step(1, 2'b00, 0, 0, 0, 0, 0);
        step(0, 2'b00, 0, 0, 0, 0, 0);

        // Preload every register, then assert reset mid-cycle with no edge
        for (int i = 1; i < 32; i++)
            step(0, 2'b10, 32'hCAFE_0000, 32'(i * 3 + 1) | 32'h0100_0000, 5'(i), 5'(i), 5'(32 - i));
        step(1, 2'b10, 0, 32'h5, 5'd4, 5'd4, 5'd9);
        step(0, 2'b00, 0, 0, 0, 0, 0);
        for (int i = 1; i < 32; i++)
            step(0, 2'b00, 0, 0, 0, 5'(i), 5'(i));

        // Basic write then read
        step(0, 2'b10, 32'h0BAD_F00D, 32'h1234_5678, 5'd5, 5'd0, 5'd0);
        step(0, 2'b00, 0, 0, 0, 5'd5, 5'd0);

        // MemtoReg select with same-cycle bypass
        step(0, 2'b11, 32'hDEAD_BEEF, 32'h0, 5'd7, 5'd0, 5'd7);
        step(0, 2'b00, 0, 0, 0, 5'd7, 5'd7);

        // Register zero
        step(0, 2'b10, 0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
        step(0, 2'b00, 0, 0, 0, 5'd0, 5'd0);

        // Bubble, then dual-port bypass
        step(0, 2'b10, 0, 32'd77, 5'd3, 5'd0, 5'd0);
        step(0, 2'b00, 0, 32'd9, 5'd3, 5'd3, 5'd3);
        step(0, 2'b10, 0, 32'd9, 5'd3, 5'd3, 5'd3);
        step(0, 2'b00, 0, 0, 0, 5'd3, 5'd3);

        // Back-to-back writes to one register
        step(0, 2'b10, 0, 32'hA, 5'd6, 5'd6, 5'd0);
        step(0, 2'b10, 0, 32'hB, 5'd6, 5'd6, 5'd6);
        step(0, 2'b00, 0, 0, 0, 5'd6, 5'd6);

        // Counter wrap: 16 commits through a 4-bit counter
        for (int i = 0; i < 16; i++)
            step(0, 2'b10, 0, 32'(i + 100), 5'(i % 31 + 1), 5'd0, 5'd0);
        step(0, 2'b00, 0, 0, 0, 5'd1, 5'd16);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            wr = 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
            step(($urandom_range(0, 63) == 0), 2'($urandom_range(0, 3)),
                 $urandom, $urandom, wr, a1, a2);
        end

        // Reset coincident with a write must lose the write
        step(0, 2'b10, 0, 32'h5555, 5'd9, 5'd0, 5'd0);
        step(1, 2'b10, 0, 32'hAAAA, 5'd9, 5'd9, 5'd9);
        step(0, 2'b00, 0, 0, 0, 5'd9, 5'd9);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 4 && sbq.size() != 0; i++) @(negedge clk);
        #1;
        n_checks++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback-side consumer of the MEM/WB pipeline register. It selects the writeback value from memory-read data or the ALU result, commits it to a 32-entry x DATA_WIDTH general-purpose register file, and serves the ID stage's two combinational read ports with same-cycle write-to-read bypass. It also keeps a retired-writeback counter for debug and performance monitoring.

## Interface
- DATA_WIDTH, 32, width of register data, memory-read data and ALU result.
- REG_NUM, 32, number of architectural registers. Address width is $clog2(REG_NUM).
- CNT_WIDTH, 32, width of the writeback counter.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_WB  in  2  writeback control from MEM/WB. Bit 1 is RegWrite; bit 0 is MemtoReg (1 selects i_dataread, 0 selects i_alures).
- i_dataread  in  DATA_WIDTH  memory-read data from MEM/WB.
- i_alures  in  DATA_WIDTH  ALU result from MEM/WB.
- i_wreg  in  5  destination register index from MEM/WB.
- i_raddr1, i_raddr2  in  5  ID-stage read addresses.
- o_rdata1, o_rdata2  out  DATA_WIDTH  read data, combinational, bypassed.
- o_wbdata  out  DATA_WIDTH  selected writeback value, combinational; feeds forwarding muxes.
- o_wben  out  1  effective write enable: RegWrite and i_wreg != 0.
- o_wbcount  out  CNT_WIDTH  count of committed writes, registered.

## Operation
- Writeback mux: o_wbdata = i_WB[0] ? i_dataread : i_alures. It is purely combinational and valid regardless of RegWrite.
- Commit: at the rising edge of clk with o_wben = 1, reg[i_wreg] <= o_wbdata.
- Register 0 is hardwired to zero.
  - Writes to index 0 are discarded.
  - o_wben stays 0 for index 0.
  - Reads of index 0 return 0 even while a write to 0 is presented.
- Read port k (k = 1, 2):
  - If i_raddrk != 0, o_wben = 1 and i_raddrk == i_wreg, then o_rdatak = o_wbdata (bypass).
  - Otherwise o_rdatak = reg[i_raddrk].
  - The two ports are independent; both may hit the same address or both may bypass.
- Counter: o_wbcount increments by 1 on each edge where o_wben = 1. It wraps from 2^CNT_WIDTH-1 to 0 silently.
- i_WB = 2'b00 (bubble inserted by the pipeline reset or flush) is a no-op: no write and no count.

## Timing
- Write latency: 1 cycle. A value presented in cycle N is architecturally visible from reg in cycle N+1. Through the bypass it is visible in cycle N itself.
- Read latency: 0 cycles. This is the combinational path from i_raddrk, i_WB, i_wreg and the data inputs to o_rdatak.
- Reset (asynchronous assert, takes effect without a clock edge):
  - All registers clear to 0.
  - o_wbcount clears to 0.
  - While rst = 1, o_rdata1, o_rdata2 and o_wben are forced to 0 and no commit occurs. o_wbdata still reflects the mux.
- Reset deassertion: the first commit can occur on the first rising edge with rst = 0.
- Reset mid-operation: a write whose edge coincides with rst = 1 is lost. The bench must see reg = 0 afterwards.
- Back-to-back writes to the same register in consecutive cycles: the last one wins. The bypass always reflects the current-cycle write, never a stale registered value.
- Simultaneous write to register A and read of register A: the new value is returned (write-first).

## Test plan
- Reset check: assert rst with registers preloaded and no clock edge -> all reads return 0 and o_wbcount = 0 immediately. After deassert, reading each index 1..31 returns 0.
- Basic write/read: i_WB = 2'b10, i_alures = 32'h1234_5678, i_wreg = 5; next cycle i_raddr1 = 5 -> o_rdata1 = 32'h1234_5678 and o_wbcount = 1.
- MemtoReg select and bypass: i_WB = 2'b11, i_dataread = 32'hDEAD_BEEF, i_alures = 32'h0, i_wreg = 7, i_raddr2 = 7 in the same cycle -> o_rdata2 = 32'hDEAD_BEEF in that cycle and reg[7] = 32'hDEAD_BEEF after the edge.
- Register zero: i_WB = 2'b10, i_wreg = 0, i_alures = 32'hFFFF_FFFF, i_raddr1 = 0 -> o_rdata1 = 0, o_wben = 0, o_wbcount unchanged. Next cycle reg[0] still reads 0.
- Bubble and dual port:
  - i_WB = 2'b00 with i_wreg = 3 and i_alures = 9 -> reg[3] keeps its previous value and the count is unchanged.
  - Then i_WB = 2'b10 with i_alures = 9 and i_raddr1 = i_raddr2 = 3 -> both ports return 9 via the bypass.
- Reset collision and counter wrap:
  - CNT_WIDTH = 4: 16 consecutive writes -> o_wbcount wraps to 0.
  - Raise rst coincident with a write of 32'hAAAA to reg 9 -> after release, reg 9 reads 0.
